fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front end of the multi-cycle 16-bit core. Owns the PC and the instruction register (IR).
- Reads instruction words from memory on request from the control state machine and presents the latched word on `instruction`.
- Applies the PC-update mode (`pcEn`) driven by the control state machine: increment, conditional jump to register, or conditional PC-relative branch, with condition evaluation from the PSR flags.

Parameters:
- ADDR_W, 16, PC and memory address width
- DATA_W, 16, instruction word width
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  control FSM in FETCH; request a read of the word at PC
- pcEn  in  2  PC update mode: 00 hold, 01 PC+1, 10 jump-if-cond to jump_target, 11 branch-if-cond by disp
- cond  in  4  condition code; control drives 4'b1110 for JAL
- disp  in  8  signed branch displacement (instruction[7:0])
- jump_target  in  ADDR_W  target register value for jumps
- flags  in  5  PSR {C,L,F,Z,N}
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  mem_rdata valid this cycle
- mem_addr  out  ADDR_W  read address, always equal to pc
- mem_rd  out  1  read strobe
- instruction  out  DATA_W  IR contents
- ir_valid  out  1  one-cycle pulse: IR updated at the last edge
- pc  out  ADDR_W  current PC
- pc_plus1  out  ADDR_W  pc+1 mod 2^ADDR_W, the JAL link value
- taken  out  1  registered: the last conditional PC update was taken
- busy  out  1  high in WAIT or while a fetch is pending
- err  out  1  sticky: pcEn≠00 arrived while in WAIT

Behaviour:
- Reset state: pc=RESET_PC, instruction=0, ir_valid=0, mem_rd=0, taken=0, err=0, pending=0, state IDLE.
- Reset asserted mid-WAIT aborts the read; mem_rd is low after that edge. A stale mem_valid arriving in IDLE is ignored.
- States:
  - IDLE:
    - fetch_req=1 and pcEn=00 → WAIT.
    - pcEn≠00 → apply the PC update. If fetch_req is also high, set pending=1 and stay in IDLE.
    - pending=1 with pcEn=00 → clear pending, go to WAIT. The read uses the updated PC.
  - WAIT:
    - mem_rd=1 for the whole state.
    - On mem_valid=1: instruction<=mem_rdata, ir_valid=1 for the next cycle, → IDLE.
    - fetch_req is ignored.
    - pcEn≠00 is ignored (PC unchanged) and sets err.
- Latency: fetch_req sampled at edge k. mem_rd is high after edge k. With mem_valid at edge k+1, instruction is valid after edge k+1. Minimum 2 cycles from request to ir_valid. Any extra memory wait states extend WAIT indefinitely; there is no timeout.
- PC update (IDLE only):
  - 01: pc<=pc+1.
  - 10: pc<=cond_true ? jump_target : pc+1.
  - 11: pc<=cond_true ? pc+sext16(disp) : pc+1.
  - taken<=cond_true on 10/11; taken<=0 on 01.
- All PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1=16'h0000; 16'h0001+sext(8'hFE)=16'hFFFF.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 HI L; 0101 LS !L
  - 0110 GT N; 0111 LE !N
  - 1000 FS F; 1001 FC !F
  - 1010 LO !L&!Z; 1011 HS L|Z
  - 1100 LT !N&!Z; 1101 GE N|Z
  - 1110 UC 1; 1111 never 0
- Outputs: mem_addr=pc and pc_plus1 are combinational from the PC register. All other outputs are registered.

Test Plan:
- Reset, then fetch_req pulse at edge 1, mem_rdata=16'h5321 with mem_valid at edge 2 → mem_rd high cycle 1 only; instruction=16'h5321, ir_valid pulse after edge 2; pc=0000.
- pc=16'h0010, pcEn=11, cond=0000, Z=1, disp=8'hFC → pc=16'h000C, taken=1. Repeat with Z=0 → pc=16'h0011, taken=0.
- pc=16'hFFFF, pcEn=01 → pc=16'h0000. Then pcEn=10, cond=1110, jump_target=16'h1234 → pc=16'h1234, taken=1, and pc_plus1=16'h0001 before that edge.
- fetch_req and pcEn=01 on the same edge at pc=16'h0004 → pc=16'h0005, busy=1. The next edge enters WAIT with mem_addr=16'h0005.
- In WAIT with mem_valid held low for 3 cycles, drive pcEn=01 → pc unchanged, err=1 sticky, mem_rd high throughout. mem_valid then completes the fetch.
- Reset asserted in WAIT, followed by mem_valid=1 with 16'hBEEF → mem_rd=0, instruction stays 16'h0000, ir_valid=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, the control state machine and instruction memory.
// The slave modport is the fetch unit's view; master is the control/memory side.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    // Control and memory inputs to the fetch unit
    logic              fetch_req;
    logic [1:0]        pcEn;
    logic [3:0]        cond;
    logic [7:0]        disp;
    logic [ADDR_W-1:0] jump_target;
    logic [4:0]        flags;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    // Fetch unit outputs
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] instruction;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              taken;
    logic              busy;
    logic              err;

    modport master (
        output fetch_req, pcEn, cond, disp, jump_target, flags, mem_rdata, mem_valid,
        input  mem_addr, mem_rd, instruction, ir_valid, pc, pc_plus1, taken, busy, err
    );

    modport slave (
        input  fetch_req, pcEn, cond, disp, jump_target, flags, mem_rdata, mem_valid,
        output mem_addr, mem_rd, instruction, ir_valid, pc, pc_plus1, taken, busy, err
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end of the multi-cycle 16-bit core: owns PC and IR, issues instruction reads
// and applies increment / conditional jump / conditional branch PC updates.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_unit_if.slave   io_fetch
);

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic              r_mem_rd;
    logic              r_taken;
    logic              r_busy;
    logic              r_err;
    logic              r_pending;

    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_sext_disp;
    logic [ADDR_W-1:0] w_pc_branch;
    logic              w_flag_c;
    logic              w_flag_l;
    logic              w_flag_f;
    logic              w_flag_z;
    logic              w_flag_n;
    logic              w_cond_base;
    logic              w_cond_true;
    logic [ADDR_W-1:0] w_pc_upd;
    logic              w_taken_upd;

    assign {w_flag_c, w_flag_l, w_flag_f, w_flag_z, w_flag_n} = io_fetch.flags;

    assign w_pc_plus1  = r_pc + ADDR_W'(1);
    assign w_sext_disp = {{(ADDR_W-8){io_fetch.disp[7]}}, io_fetch.disp};
    assign w_pc_branch = r_pc + w_sext_disp;

    // Odd condition codes are the complement of the even code just below them.
    always_comb begin
        w_cond_base = 1'b0;
        unique case (io_fetch.cond[3:1])
            3'd0: w_cond_base = w_flag_z;
            3'd1: w_cond_base = w_flag_c;
            3'd2: w_cond_base = w_flag_l;
            3'd3: w_cond_base = w_flag_n;
            3'd4: w_cond_base = w_flag_f;
            3'd5: w_cond_base = ~w_flag_l & ~w_flag_z;
            3'd6: w_cond_base = ~w_flag_n & ~w_flag_z;
            3'd7: w_cond_base = 1'b1;
        endcase
        w_cond_true = w_cond_base ^ io_fetch.cond[0];
    end

    always_comb begin
        w_pc_upd    = w_pc_plus1;
        w_taken_upd = 1'b0;
        case (io_fetch.pcEn)
            2'b10: begin
                w_taken_upd = w_cond_true;
                if (w_cond_true) begin
                    w_pc_upd = io_fetch.jump_target;
                end
            end
            2'b11: begin
                w_taken_upd = w_cond_true;
                if (w_cond_true) begin
                    w_pc_upd = w_pc_branch;
                end
            end
            default: begin
                w_pc_upd    = w_pc_plus1;
                w_taken_upd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_taken    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_fetch.pcEn != 2'b00) begin
                        r_pc    <= w_pc_upd;
                        r_taken <= w_taken_upd;
                        // Defer the read one cycle so it uses the updated PC.
                        if (io_fetch.fetch_req) begin
                            r_pending <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end else if (io_fetch.fetch_req || r_pending) begin
                        r_state   <= StWait;
                        r_pending <= 1'b0;
                        r_mem_rd  <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                StWait: begin
                    if (io_fetch.pcEn != 2'b00) begin
                        r_err <= 1'b1;
                    end
                    if (io_fetch.mem_valid) begin
                        r_ir       <= io_fetch.mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_state    <= StIdle;
                        r_mem_rd   <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign io_fetch.mem_addr    = r_pc;
    assign io_fetch.pc          = r_pc;
    assign io_fetch.pc_plus1    = w_pc_plus1;
    assign io_fetch.mem_rd      = r_mem_rd;
    assign io_fetch.instruction = r_ir;
    assign io_fetch.ir_valid    = r_ir_valid;
    assign io_fetch.taken       = r_taken;
    assign io_fetch.busy        = r_busy;
    assign io_fetch.err         = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized update/fetch traffic, with fetched
// words checked by a scoreboard monitor against a transaction-level model of PC and flags.
module tb_fetch_unit;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    fetch_unit #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RESET_PC(16'h0000)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_fetch(bus_if)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        taken;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    // Architectural model state
    logic [15:0] m_pc;
    logic        m_taken;
    logic        m_err;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
        bit fc, fl, ff, fz, fn;
        {fc, fl, ff, fz, fn} = f;
        case (c)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fl;
            4'd5:  return !fl;
            4'd6:  return fn;
            4'd7:  return !fn;
            4'd8:  return ff;
            4'd9:  return !ff;
            4'd10: return !fl && !fz;
            4'd11: return fl || fz;
            4'd12: return !fn && !fz;
            4'd13: return fn || fz;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update(input logic [1:0] en, input logic [3:0] c, input logic [4:0] f,
                                input logic [7:0] d, input logic [15:0] jt);
        bit ok;
        int target;
        ok = cond_ok(c, f);
        target = int'(m_pc) + int'($signed(d));
        case (en)
            2'd1: begin m_pc = m_pc + 16'd1; m_taken = 1'b0; end
            2'd2: begin m_pc = ok ? jt : m_pc + 16'd1; m_taken = ok; end
            2'd3: begin m_pc = ok ? target[15:0] : m_pc + 16'd1; m_taken = ok; end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, input logic [3:0] c, input logic [4:0] f,
                         input logic [7:0] d, input logic [15:0] jt);
        bus_if.pcEn        = en;
        bus_if.cond        = c;
        bus_if.flags       = f;
        bus_if.disp        = d;
        bus_if.jump_target = jt;
    endtask

    task automatic set_pc(input logic [15:0] v);
        drive(2'b10, 4'b1110, 5'b0, 8'h00, v);
        tick();
        bus_if.pcEn = 2'b00;
        model_update(2'b10, 4'b1110, 5'b0, 8'h00, v);
        chk("set_pc", bus_if.pc, m_pc);
    endtask

    // Called once the DUT has entered WAIT; completes the read with random wait states.
    task automatic mem_phase();
        int  nwait;
        bit  bad;
        exp_t e;
        chk("wait_mem_rd", bus_if.mem_rd, 1'b1);
        chk("wait_mem_addr", bus_if.mem_addr, m_pc);
        nwait = $urandom_range(3, 0);
        bad = ($urandom_range(3, 0) == 0);
        if (bad) m_err = 1'b1;
        e.instr = mem_word(m_pc);
        e.pc    = m_pc;
        e.taken = m_taken;
        e.err   = m_err;
        sb.push_back(e);
        for (int i = 0; i < nwait; i++) begin
            bus_if.pcEn = (bad && i == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            bus_if.fetch_req = 1'($urandom);
            tick();
            bus_if.pcEn = 2'b00;
            bus_if.fetch_req = 1'b0;
            chk("wait_hold_mem_rd", bus_if.mem_rd, 1'b1);
            chk("wait_hold_pc", bus_if.pc, m_pc);
        end
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = mem_word(bus_if.mem_addr);
        bus_if.pcEn = (bad && nwait == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        tick();
        bus_if.mem_valid = 1'b0;
        bus_if.pcEn = 2'b00;
        chk("done_mem_rd", bus_if.mem_rd, 1'b0);
        if ($urandom_range(3, 0) == 0) begin
            // Stale response while idle must not reach the IR
            bus_if.mem_valid = 1'b1;
            bus_if.mem_rdata = 16'($urandom);
            tick();
            bus_if.mem_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus_if.ir_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ir_valid_unexpected: got ir_valid=1 instr=%h expected no pulse",
                         bus_if.instruction);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", bus_if.instruction, e.instr);
                chk("sb_pc", bus_if.pc, e.pc);
                chk("sb_taken", bus_if.taken, e.taken);
                chk("sb_err", bus_if.err, e.err);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0]  en;
        logic [3:0]  c;
        logic [4:0]  f;
        logic [7:0]  d;
        logic [15:0] jt;
        exp_t        e;
        int          op;

        bus_if.fetch_req = 1'b0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_rdata = '0;
        drive(2'b00, 4'd0, 5'd0, 8'd0, 16'd0);
        m_pc = 16'h0000; m_taken = 1'b0; m_err = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pc", bus_if.pc, 16'h0000);
        chk("rst_instr", bus_if.instruction, 16'h0000);
        chk("rst_ir_valid", bus_if.ir_valid, 1'b0);
        chk("rst_mem_rd", bus_if.mem_rd, 1'b0);
        chk("rst_taken", bus_if.taken, 1'b0);
        chk("rst_err", bus_if.err, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);

        // Minimum-latency fetch
        bus_if.fetch_req = 1'b1;
        tick();
        bus_if.fetch_req = 1'b0;
        chk("f1_mem_rd", bus_if.mem_rd, 1'b1);
        chk("f1_busy", bus_if.busy, 1'b1);
        chk("f1_mem_addr", bus_if.mem_addr, 16'h0000);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = 16'h5321;
        e.instr = 16'h5321; e.pc = 16'h0000; e.taken = 1'b0; e.err = 1'b0;
        sb.push_back(e);
        tick();
        bus_if.mem_valid = 1'b0;
        chk("f2_mem_rd", bus_if.mem_rd, 1'b0);
        chk("f2_ir_valid", bus_if.ir_valid, 1'b1);
        chk("f2_instr", bus_if.instruction, 16'h5321);
        chk("f2_busy", bus_if.busy, 1'b0);
        tick();
        chk("f3_ir_valid", bus_if.ir_valid, 1'b0);
        chk("f3_instr", bus_if.instruction, 16'h5321);

        // Conditional branch taken / not taken
        set_pc(16'h0010);
        drive(2'b11, 4'b0000, 5'b00010, 8'hFC, 16'h0000);
        tick();
        bus_if.pcEn = 2'b00;
        chk("br_taken_pc", bus_if.pc, 16'h000C);
        chk("br_taken_flag", bus_if.taken, 1'b1);
        m_pc = 16'h000C;
        set_pc(16'h0010);
        drive(2'b11, 4'b0000, 5'b00000, 8'hFC, 16'h0000);
        tick();
        bus_if.pcEn = 2'b00;
        chk("br_nt_pc", bus_if.pc, 16'h0011);
        chk("br_nt_flag", bus_if.taken, 1'b0);
        m_pc = 16'h0011; m_taken = 1'b0;

        // Wraparound, then unconditional jump
        set_pc(16'hFFFF);
        chk("wrap_pc_plus1", bus_if.pc_plus1, 16'h0000);
        drive(2'b01, 4'b0000, 5'b00000, 8'h00, 16'h0000);
        tick();
        bus_if.pcEn = 2'b00;
        chk("wrap_pc", bus_if.pc, 16'h0000);
        chk("wrap_taken", bus_if.taken, 1'b0);
        drive(2'b10, 4'b1110, 5'b00000, 8'h00, 16'h1234);
        chk("jal_link", bus_if.pc_plus1, 16'h0001);
        tick();
        bus_if.pcEn = 2'b00;
        chk("jal_pc", bus_if.pc, 16'h1234);
        chk("jal_taken", bus_if.taken, 1'b1);
        m_pc = 16'h1234; m_taken = 1'b1;

        // Branch with 0x0001 + sext(0xFE)
        set_pc(16'h0001);
        drive(2'b11, 4'b1110, 5'b00000, 8'hFE, 16'h0000);
        tick();
        bus_if.pcEn = 2'b00;
        chk("br_neg_wrap", bus_if.pc, 16'hFFFF);
        m_pc = 16'hFFFF;

        // Fetch together with increment, then WAIT with an illegal update
        set_pc(16'h0004);
        bus_if.fetch_req = 1'b1;
        drive(2'b01, 4'b0000, 5'b00000, 8'h00, 16'h0000);
        tick();
        bus_if.fetch_req = 1'b0;
        bus_if.pcEn = 2'b00;
        model_update(2'b01, 4'b0000, 5'b00000, 8'h00, 16'h0000);
        chk("pend_pc", bus_if.pc, 16'h0005);
        chk("pend_busy", bus_if.busy, 1'b1);
        chk("pend_mem_rd", bus_if.mem_rd, 1'b0);
        tick();
        chk("pend_wait_mem_rd", bus_if.mem_rd, 1'b1);
        chk("pend_wait_addr", bus_if.mem_addr, 16'h0005);
        tick();
        bus_if.pcEn = 2'b01;
        tick();
        bus_if.pcEn = 2'b00;
        chk("werr_pc", bus_if.pc, 16'h0005);
        chk("werr_err", bus_if.err, 1'b1);
        chk("werr_mem_rd", bus_if.mem_rd, 1'b1);
        tick();
        chk("werr_mem_rd2", bus_if.mem_rd, 1'b1);
        m_err = 1'b1;
        e.instr = mem_word(16'h0005); e.pc = 16'h0005; e.taken = 1'b0; e.err = 1'b1;
        sb.push_back(e);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = mem_word(bus_if.mem_addr);
        tick();
        bus_if.mem_valid = 1'b0;
        chk("werr_done_mem_rd", bus_if.mem_rd, 1'b0);
        tick();
        chk("werr_sticky", bus_if.err, 1'b1);

        // Reset mid-WAIT aborts the read
        bus_if.fetch_req = 1'b1;
        tick();
        bus_if.fetch_req = 1'b0;
        chk("rw_mem_rd", bus_if.mem_rd, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_mem_rd_rst", bus_if.mem_rd, 1'b0);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = 16'hBEEF;
        tick();
        bus_if.mem_valid = 1'b0;
        chk("rw_mem_rd_after", bus_if.mem_rd, 1'b0);
        chk("rw_instr", bus_if.instruction, 16'h0000);
        chk("rw_ir_valid", bus_if.ir_valid, 1'b0);
        chk("rw_pc", bus_if.pc, 16'h0000);
        chk("rw_err", bus_if.err, 1'b0);
        m_pc = 16'h0000; m_taken = 1'b0; m_err = 1'b0;

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(2, 0);
            en = 2'($urandom_range(3, 1));
            c  = 4'($urandom);
            f  = 5'($urandom);
            d  = 8'($urandom);
            jt = 16'($urandom);
            case (op)
                0: begin
                    drive(en, c, f, d, jt);
                    tick();
                    bus_if.pcEn = 2'b00;
                    model_update(en, c, f, d, jt);
                    chk("rnd_pc", bus_if.pc, m_pc);
                    chk("rnd_taken", bus_if.taken, m_taken);
                    chk("rnd_pc_plus1", bus_if.pc_plus1, m_pc + 16'd1);
                    chk("rnd_busy", bus_if.busy, 1'b0);
                end
                1: begin
                    bus_if.fetch_req = 1'b1;
                    tick();
                    bus_if.fetch_req = 1'b0;
                    mem_phase();
                end
                default: begin
                    bus_if.fetch_req = 1'b1;
                    drive(en, c, f, d, jt);
                    tick();
                    bus_if.fetch_req = 1'b0;
                    bus_if.pcEn = 2'b00;
                    model_update(en, c, f, d, jt);
                    chk("rnd_pend_pc", bus_if.pc, m_pc);
                    chk("rnd_pend_busy", bus_if.busy, 1'b1);
                    chk("rnd_pend_mem_rd", bus_if.mem_rd, 1'b0);
                    tick();
                    mem_phase();
                end
            endcase
        end

        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
